// File: rtl/div_unit_pkg.sv
// Shared EX-stage definitions: ALU control codes and divider state encodings.
package div_unit_pkg;

    localparam logic [4:0] ADD_CONTROL  = 5'b00010;
    localparam logic [4:0] DIV_CONTROL  = 5'b01110;
    localparam logic [4:0] DIVU_CONTROL = 5'b01111;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_BUSY  = 2'd1,
        DIV_DZERO = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: request from the decoder side, stall/done/results back.
interface div_unit_if #(parameter int WIDTH = 32);

    logic             en;
    logic [4:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             stall_div;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output en, alucontrol, a, b, cancel,
        input  stall_div, done, hi_out, lo_out
    );

    modport slave (
        input  en, alucontrol, a, b, cancel,
        output stall_div, done, hi_out, lo_out
    );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), quotient to LO, remainder to HI.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             is_div, sgn, start;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    always_comb begin
        is_div = (bus.alucontrol == DIV_CONTROL) || (bus.alucontrol == DIVU_CONTROL);
        sgn    = (bus.alucontrol == DIV_CONTROL);
        start  = bus.en && is_div && (state_q == DIV_IDLE) && !bus.cancel && !rst;
        // Shifted-in partial remainder is WIDTH+1 bits; MSB of the difference is the borrow.
        trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    qneg_d = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rneg_d = sgn && bus.a[WIDTH-1];
                    rem_d  = '0;
                    cnt_d  = '0;
                    dvs_d  = neg_if(sgn && bus.b[WIDTH-1], bus.b);
                    if (bus.b == '0) begin
                        // Divide-by-zero keeps the raw dividend for HI.
                        quo_d   = bus.a;
                        state_d = DIV_DZERO;
                    end else begin
                        quo_d   = neg_if(sgn && bus.a[WIDTH-1], bus.a);
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    lo_d    = neg_if(qneg_q, quo_d);
                    hi_d    = neg_if(rneg_q, rem_d);
                    done_d  = 1'b1;
                    state_d = DIV_DONE;
                end
            end
            DIV_DZERO: begin
                lo_d    = '1;
                hi_d    = quo_q;
                done_d  = 1'b1;
                state_d = DIV_DONE;
            end
            default: state_d = DIV_IDLE;
        endcase

        if (bus.cancel && state_q != DIV_IDLE) begin
            state_d = DIV_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.stall_div = start || (state_q == DIV_BUSY) || (state_q == DIV_DZERO);
    assign bus.done      = done_q;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, cancel/reset cases and random ops vs. an arithmetic model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (op == DIV_CONTROL) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Issue one op and watch it: stall cycles, cycle index of done, stall/done overlap, done width.
    task automatic do_div(input logic [4:0] op, input logic [31:0] da, input logic [31:0] db,
                          output logic [31:0] lo, output logic [31:0] hi,
                          output int nst, output int didx, output int overlap, output logic done_after);
        @(negedge clk);
        bus.en = 1'b1; bus.alucontrol = op; bus.a = da; bus.b = db;
        nst = 0; didx = -1; overlap = 0;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (bus.stall_div) nst++;
            if (bus.stall_div && bus.done) overlap++;
            if (bus.done) begin didx = c; break; end
            @(posedge clk); #1 bus.en = 1'b0;
            @(negedge clk); #1;
        end
        bus.en = 1'b0;
        lo = bus.lo_out; hi = bus.hi_out;
        @(negedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic check_op(input string name, input logic [4:0] op, input logic [31:0] da, input logic [31:0] db);
        logic [31:0] lo, hi, elo, ehi;
        int nst, didx, ov, elat;
        logic dn;
        model(op, da, db, elo, ehi);
        elat = (db == 32'd0) ? 2 : 33;
        do_div(op, da, db, lo, hi, nst, didx, ov, dn);
        checks++;
        if (lo !== elo) begin failures++; $display("FAIL %s lo got=%h exp=%h", name, lo, elo); end
        checks++;
        if (hi !== ehi) begin failures++; $display("FAIL %s hi got=%h exp=%h", name, hi, ehi); end
        checks++;
        if (didx !== elat) begin failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, didx, elat); end
        checks++;
        if (nst !== elat) begin failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, nst, elat); end
        checks++;
        if (ov !== 0 || dn !== 1'b0) begin
            failures++; $display("FAIL %s done_pulse overlap=%0d done_next=%b exp 0/0", name, ov, dn);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.alucontrol = 5'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        #3;
        checks++;
        if ({bus.stall_div, bus.done, bus.hi_out, bus.lo_out} !== 66'd0) begin
            failures++;
            $display("FAIL reset stall=%b done=%b hi=%h lo=%h exp all 0", bus.stall_div, bus.done, bus.hi_out, bus.lo_out);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        check_op("divu_100_7",     DIVU_CONTROL, 32'd100,       32'd7);
        check_op("div_m7_2",       DIV_CONTROL,  32'hFFFF_FFF9, 32'd2);
        check_op("div_7_m2",       DIV_CONTROL,  32'd7,         32'hFFFF_FFFE);
        check_op("div_ovf",        DIV_CONTROL,  32'h8000_0000, 32'hFFFF_FFFF);
        check_op("divu_ovf_ops",   DIVU_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("divu_by_zero",   DIVU_CONTROL, 32'h0000_1234, 32'd0);
        check_op("div_neg_by_zero",DIV_CONTROL,  32'hFFFF_FF00, 32'd0);
    endtask

    task automatic test_cancel();
        logic [31:0] plo, phi;
        int spurious;
        plo = bus.lo_out; phi = bus.hi_out;
        @(negedge clk);
        bus.en = 1'b1; bus.alucontrol = DIV_CONTROL; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1 bus.en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); bus.cancel = 1'b1;
        @(negedge clk); bus.cancel = 1'b0; #1;
        checks++;
        if (bus.stall_div !== 1'b0) begin failures++; $display("FAIL cancel_idle stall got=%b exp=0", bus.stall_div); end
        spurious = 0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); #1; if (bus.done) spurious++; end
        checks++;
        if (spurious !== 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", spurious); end
        checks++;
        if (bus.lo_out !== plo || bus.hi_out !== phi) begin
            failures++; $display("FAIL cancel_hold lo=%h hi=%h exp lo=%h hi=%h", bus.lo_out, bus.hi_out, plo, phi);
        end
        check_op("divu_9_3_after_cancel", DIVU_CONTROL, 32'd9, 32'd3);

        // Cancel coincident with a start request blocks the start.
        @(negedge clk);
        bus.en = 1'b1; bus.alucontrol = DIVU_CONTROL; bus.a = 32'd50; bus.b = 32'd5; bus.cancel = 1'b1; #1;
        checks++;
        if (bus.stall_div !== 1'b0) begin failures++; $display("FAIL cancel_start stall got=%b exp=0", bus.stall_div); end
        @(posedge clk); #1 bus.en = 1'b0; bus.cancel = 1'b0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); #1; if (bus.done || bus.stall_div) spurious++; end
        checks++;
        if (spurious !== 0) begin failures++; $display("FAIL cancel_start_idle activity=%0d exp=0", spurious); end
    endtask

    task automatic test_non_div();
        int act;
        act = 0;
        @(negedge clk);
        bus.en = 1'b1; bus.alucontrol = ADD_CONTROL; bus.a = 32'd5; bus.b = 32'd6;
        for (int c = 0; c < 8; c++) begin #1; if (bus.stall_div || bus.done) act++; @(negedge clk); end
        bus.en = 1'b0;
        checks++;
        if (act !== 0) begin failures++; $display("FAIL non_div activity got=%0d exp=0", act); end
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? DIV_CONTROL : DIVU_CONTROL;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            check_op($sformatf("rand%0d", i), op, ra, rb);
        end
    endtask

    task automatic test_async_reset();
        int spurious;
        check_op("pre_reset_load", DIVU_CONTROL, 32'd77, 32'd5);
        @(negedge clk);
        bus.en = 1'b1; bus.alucontrol = DIVU_CONTROL; bus.a = 32'hDEAD_BEEF; bus.b = 32'd13;
        @(posedge clk); #1 bus.en = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.stall_div, bus.done, bus.hi_out, bus.lo_out} !== 66'd0) begin
            failures++;
            $display("FAIL async_reset stall=%b done=%b hi=%h lo=%h exp all 0", bus.stall_div, bus.done, bus.hi_out, bus.lo_out);
        end
        @(negedge clk); rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); #1; if (bus.done || bus.stall_div) spurious++; end
        checks++;
        if (spurious !== 0) begin failures++; $display("FAIL async_reset_idle activity=%0d exp=0", spurious); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_cancel();
        test_non_div();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
